univ_shiftreg: RTL and testbench
================================

UNIV_SHIFTREG -- requirements
Module: univ_shiftreg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, legal range 2 to 64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1: width of the step-count input.
REQ-003 c  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 load  input  1  parallel load request.
REQ-006 d  input  WIDTH  parallel load data.
REQ-007 start  input  1  begin a multi-step operation.
REQ-008 mode  input  3  operation select, sampled with start.
REQ-009 amt  input  CNT_W  number of steps, sampled with start.
REQ-010 si  input  1  serial input, sampled live on every step.
REQ-011 q  output  WIDTH  register contents.
REQ-012 busy  output  1  high while steps are being applied.
REQ-013 done  output  1  single-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; busy is high only in RUN, and done is high only in DONE.
REQ-015 The mode encoding SHALL be: 000 hold; 001 rotate left (q[k]<=q[k-1], q[0]<=q[WIDTH-1]); 010 rotate right; 011 shift left with si into q[0]; 100 shift right with si into q[WIDTH-1]; 101 arithmetic shift right (MSB replicated); 110 and 111 act as hold.
REQ-016 In IDLE or DONE, load=1 SHALL set q<=d at the next edge with the next state IDLE; load has priority over start.
REQ-017 In IDLE or DONE, start=1 with load=0 SHALL latch mode and amt with q unchanged; the next state is RUN if amt>0 and DONE if amt==0.
REQ-018 Each edge in RUN SHALL apply exactly one step of the latched mode and decrement the internal count; the edge that applies the final step SHALL move the FSM to DONE.
REQ-019 With start accepted at edge T and amt=N>0, busy SHALL be high after edges T..T+N-1, q SHALL hold the N-step result after edge T+N, and done SHALL be high for exactly the one cycle after edge T+N.
REQ-020 An amt greater than WIDTH SHALL be executed literally, performing amt single steps with no modulo reduction.
REQ-021 Changes to mode and amt while in RUN SHALL be ignored, and start while in RUN SHALL be ignored.
REQ-022 load=1 while in RUN SHALL abort the operation: q<=d, next state IDLE, and no done pulse is produced.
REQ-023 A start or load presented in DONE SHALL be accepted in the same way as in IDLE, allowing back-to-back operations with no idle gap.
REQ-024 Absent load and start, the FSM SHALL remain in IDLE with q held.

Reset
REQ-025 rst_n=0 SHALL immediately force q=0, state IDLE, busy=0, done=0, internal count 0 and latched mode 000, independent of c.
REQ-026 Reset asserted in RUN SHALL discard the operation with no done pulse; after release the block SHALL accept load or start on the first rising edge.

Configuration
REQ-027 With macro UNIV_SHIFTREG_PARITY_EN defined, the block SHALL add output port par (input-free, 1 bit) equal to the combinational XOR reduction of q, which reads 0 during reset.
REQ-028 Without UNIV_SHIFTREG_PARITY_EN, port par and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 WIDTH=4: load d=0011, then start mode=001 amt=1 -> q=0110 one edge after the RUN step, with a single done pulse.
REQ-030 WIDTH=4: q=0011, start mode=001 amt=4 -> busy high for 4 cycles, q steps through 0110, 1100, 1001, 0011, and done pulses once.
REQ-031 WIDTH=8: q=10000000, start mode=101 amt=3 -> q=11110000; then start mode=100 amt=2 with si=0 -> q=00111100.
REQ-032 WIDTH=4: q=0001, start mode=011 amt=2 with si=1 -> q=0111; start with amt=0 -> q unchanged, done high the cycle after the start edge, busy never high.
REQ-033 WIDTH=8: start mode=010 amt=5, then load d=A5 on the second RUN cycle -> q=A5, state IDLE, no done pulse; rst_n pulsed low mid-RUN -> q=00 immediately, busy=0.
REQ-034 Parity build with WIDTH=4: load 0111 -> par=1; rotate left once -> q=1110, par=1; load 0101 -> par=0.

Source files
------------

// File: rtl/univ_shiftreg.sv
// Universal shift register: parallel load plus multi-step rotate/shift/arith-shift sequencer.
// Optional parity output `par` enabled by defining UNIV_SHIFTREG_PARITY_EN.
module univ_shiftreg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
`ifdef UNIV_SHIFTREG_PARITY_EN
    ,
    output logic             par
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_ROL  = 3'b001,
        OP_ROR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_SHR  = 3'b100,
        OP_ASR  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_t;

    state_t           state;
    state_t           state_nx;
    op_t              op_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] step;

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Load wins over start everywhere, and in RUN it also aborts without a done pulse.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (load) begin
                    state_nx = IDLE;
                end else if (start) begin
                    state_nx = (amt != '0) ? RUN : DONE;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (load) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_comb begin
        step = q;
        case (op_r)
            OP_ROL:  step = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  step = {q[0], q[WIDTH-1:1]};
            OP_SHL:  step = {q[WIDTH-2:0], si};
            OP_SHR:  step = {si, q[WIDTH-1:1]};
            OP_ASR:  step = {q[WIDTH-1], q[WIDTH-1:1]};
            default: step = q;
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            cnt  <= '0;
            op_r <= OP_HOLD;
        end else if (load) begin
            q <= d;
        end else if (state != RUN) begin
            if (start) begin
                op_r <= op_t'(mode);
                cnt  <= amt;
            end
        end else begin
            q   <= step;
            cnt <= cnt - CNT_W'(1);
        end
    end

`ifdef UNIV_SHIFTREG_PARITY_EN
    assign par = ^q;
`endif

endmodule

// File: tb/tb_univ_shiftreg.sv
// Scoreboard bench for univ_shiftreg: WIDTH=8 and WIDTH=4 instances driven by one stimulus stream.
module tb_univ_shiftreg;

    logic       c = 1'b0;
    logic       rst_n;
    logic       load;
    logic       start;
    logic       si;
    logic [7:0] d;
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] q8;
    logic [3:0] q4;
    logic       busy8, done8, busy4, done4;
`ifdef UNIV_SHIFTREG_PARITY_EN
    logic       par8, par4;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic [7:0] q8;
        logic [3:0] q4;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq8;
    logic [3:0] mq4;

    always #5 c = ~c;

    univ_shiftreg #(.WIDTH(8)) u_dut8 (
        .c(c), .rst_n(rst_n), .load(load), .d(d), .start(start), .mode(mode),
        .amt(amt), .si(si), .q(q8), .busy(busy8), .done(done8)
`ifdef UNIV_SHIFTREG_PARITY_EN
        , .par(par8)
`endif
    );

    univ_shiftreg #(.WIDTH(4)) u_dut4 (
        .c(c), .rst_n(rst_n), .load(load), .d(d[3:0]), .start(start), .mode(mode),
        .amt(amt[2:0]), .si(si), .q(q4), .busy(busy4), .done(done4)
`ifdef UNIV_SHIFTREG_PARITY_EN
        , .par(par4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref8(input logic [7:0] v, input logic [2:0] m,
                                        input int unsigned n, input logic s);
        logic [7:0] r;
        r = v;
        for (int unsigned i = 0; i < n; i++) begin
            case (m)
                3'b001:  r = (r << 1) | (r >> 7);
                3'b010:  r = (r >> 1) | (r << 7);
                3'b011:  r = (r << 1) | {7'd0, s};
                3'b100:  r = (r >> 1) | {s, 7'd0};
                3'b101:  r = (r >> 1) | (r & 8'h80);
                default: r = r;
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] ref4(input logic [3:0] v, input logic [2:0] m,
                                        input int unsigned n, input logic s);
        logic [3:0] r;
        r = v;
        for (int unsigned i = 0; i < n; i++) begin
            case (m)
                3'b001:  r = (r << 1) | (r >> 3);
                3'b010:  r = (r >> 1) | (r << 3);
                3'b011:  r = (r << 1) | {3'd0, s};
                3'b100:  r = (r >> 1) | {s, 3'd0};
                3'b101:  r = (r >> 1) | (r & 4'h8);
                default: r = r;
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check_par();
`ifdef UNIV_SHIFTREG_PARITY_EN
        check("par8", par8, ^mq8);
        check("par4", par4, ^mq4);
`endif
    endtask

    task automatic do_load(input logic [7:0] dv);
        exp_t e;
        d    = dv;
        load = 1'b1;
        mq8  = dv;
        mq4  = dv[3:0];
        sb.push_back('{q8: dv, q4: dv[3:0]});
        tick();
        load = 1'b0;
        e = sb.pop_front();
        check("load_q8", q8, e.q8);
        check("load_q4", q4, e.q4);
        check("load_busy", {busy8, busy4}, 2'b00);
        check("load_done", {done8, done4}, 2'b00);
        check_par();
    endtask

    task automatic run_op(input logic [2:0] m, input int unsigned n, input logic s,
                          input bit disturb);
        exp_t        e;
        logic [7:0]  q8_0;
        logic [3:0]  q4_0;
        int unsigned bcnt8, bcnt4, dcyc;
        bit          seen;
        q8_0 = mq8;
        q4_0 = mq4;
        mq8  = ref8(mq8, m, n, s);
        mq4  = ref4(mq4, m, n, s);
        sb.push_back('{q8: mq8, q4: mq4});
        mode  = m;
        amt   = n[3:0];
        si    = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        bcnt8 = 0;
        bcnt4 = 0;
        dcyc  = 0;
        seen  = 1'b0;
        for (int unsigned cyc = 0; cyc < 64 && !seen; cyc++) begin
            if (done8) begin
                seen = 1'b1;
                dcyc = cyc;
                check("done4_sync", done4, 1'b1);
            end else begin
                if (busy8) bcnt8++;
                if (busy4) bcnt4++;
                check("step_q8", q8, ref8(q8_0, m, cyc, s));
                check("step_q4", q4, ref4(q4_0, m, cyc, s));
                if (disturb && cyc == 1) begin
                    mode  = ~m;
                    amt   = 4'd1;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                tick();
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1'b1);
        check("done_lat", dcyc, n);
        check("busy_cnt8", bcnt8, n);
        check("busy_cnt4", bcnt4, n);
        e = sb.pop_front();
        check("op_q8", q8, e.q8);
        check("op_q4", q4, e.q4);
        check_par();
    endtask

    task automatic idle_check();
        tick();
        check("idle_done", {done8, done4}, 2'b00);
        check("idle_busy", {busy8, busy4}, 2'b00);
        check("idle_q8", q8, mq8);
        check("idle_q4", q4, mq4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        si    = 1'b0;
        d     = '0;
        mode  = '0;
        amt   = '0;
        mq8   = '0;
        mq4   = '0;
        #3;
        check("rst_q8", q8, 8'h00);
        check("rst_q4", q4, 4'h0);
        check("rst_busy", {busy8, busy4}, 2'b00);
        check("rst_done", {done8, done4}, 2'b00);
        check_par();
        @(negedge c);
        rst_n = 1'b1;

        // Single rotate left, then a full-width rotate with start/mode/amt disturbed mid-run
        do_load(8'h03);
        run_op(3'b001, 1, 1'b0, 1'b0);
        idle_check();
        do_load(8'h03);
        run_op(3'b001, 4, 1'b0, 1'b1);
        idle_check();

        // Arithmetic shift then back-to-back logical shift right
        do_load(8'h80);
        run_op(3'b101, 3, 1'b0, 1'b0);
        run_op(3'b100, 2, 1'b0, 1'b0);
        idle_check();

        do_load(8'h01);
        run_op(3'b011, 2, 1'b1, 1'b0);
        run_op(3'b001, 0, 1'b0, 1'b0);
        idle_check();

        // Counts above the 4-bit width execute literally; reserved modes hold
        do_load(8'hB4);
        run_op(3'b010, 6, 1'b0, 1'b1);
        run_op(3'b011, 7, 1'b1, 1'b0);
        run_op(3'b110, 2, 1'b0, 1'b0);
        run_op(3'b111, 3, 1'b1, 1'b0);
        run_op(3'b000, 2, 1'b1, 1'b0);
        run_op(3'b100, 5, 1'b1, 1'b1);
        run_op(3'b101, 7, 1'b0, 1'b0);
        repeat (3) idle_check();

        // Load during RUN aborts with no done pulse
        do_load(8'h3C);
        mode  = 3'b010;
        amt   = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_busy", {busy8, busy4}, 2'b11);
        tick();
        d    = 8'hA5;
        load = 1'b1;
        tick();
        load = 1'b0;
        mq8  = 8'hA5;
        mq4  = 4'h5;
        check("abort_q8", q8, 8'hA5);
        check("abort_q4", q4, 4'h5);
        check("abort_busy_off", {busy8, busy4}, 2'b00);
        repeat (5) idle_check();

        // Asynchronous reset mid-run
        do_load(8'h5A);
        mode  = 3'b001;
        amt   = 4'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        mq8 = '0;
        mq4 = '0;
        check("arst_q8", q8, 8'h00);
        check("arst_q4", q4, 4'h0);
        check("arst_busy", {busy8, busy4}, 2'b00);
        check("arst_done", {done8, done4}, 2'b00);
        check_par();
        @(negedge c);
        rst_n = 1'b1;
        do_load(8'hC3);
        run_op(3'b001, 2, 1'b0, 1'b0);
        idle_check();

        // Parity-oriented sequence (also exercises the default build)
        do_load(8'h07);
        run_op(3'b001, 1, 1'b0, 1'b0);
        do_load(8'h05);
        idle_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
